// File: rtl/spi_frame_sequencer_if.sv
// Command, TX/RX stream, SpiBase core and chip-select signals of the SPI frame sequencer.
// master: the sequencer itself; slave: the front end / SpiBase side driving it.
interface spi_frame_sequencer_if #(
    parameter int MAX_WORD_SIZE = 32,
    parameter int NUM_CS        = 4
);
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic                     cmdValid;
    logic                     cmdReady;
    logic [CSW-1:0]           cmdCs;
    logic [7:0]               cmdWords;
    logic                     cmdRxDiscard;
    logic [7:0]               setupCycles;
    logic [7:0]               gapCycles;
    logic [7:0]               holdCycles;

    logic                     txValid;
    logic                     txReady;
    logic [MAX_WORD_SIZE-1:0] txData;

    logic                     rxValid;
    logic                     rxReady;
    logic [MAX_WORD_SIZE-1:0] rxData;

    logic                     coreStart;
    logic [MAX_WORD_SIZE-1:0] coreSendData;
    logic                     coreReady;
    logic                     coreBusy;
    logic [MAX_WORD_SIZE-1:0] coreRecvData;

    logic [NUM_CS-1:0]        CS_N;
    logic                     active;

    modport master (
        input  cmdValid, cmdCs, cmdWords, cmdRxDiscard,
        input  setupCycles, gapCycles, holdCycles,
        input  txValid, txData, rxReady,
        input  coreReady, coreBusy, coreRecvData,
        output cmdReady, txReady, rxValid, rxData,
        output coreStart, coreSendData, CS_N, active
    );

    modport slave (
        output cmdValid, cmdCs, cmdWords, cmdRxDiscard,
        output setupCycles, gapCycles, holdCycles,
        output txValid, txData, rxReady,
        output coreReady, coreBusy, coreRecvData,
        input  cmdReady, txReady, rxValid, rxData,
        input  coreStart, coreSendData, CS_N, active
    );
endinterface

// File: rtl/spi_frame_sequencer.sv
// Burst sequencer in front of SpiBase: owns chip-select timing, feeds TX words one at a
// time into the shift engine and returns received words through a one-deep RX slot.
//
// state | meaning
// IDLE  | cmdReady high, CS_N all high
// SETUP | CS asserted, counting setupCycles (lasts setupCycles+1 cycles)
// FETCH | waiting for a TX word with a free RX slot and an idle core
// WAIT  | word in flight, waiting for coreReady
// GAP   | idle between words (lasts exactly gapCycles cycles)
// HOLD  | counting down before CS_N rises, then one cycle before IDLE
module spi_frame_sequencer #(
    parameter int MAX_WORD_SIZE = 32,
    parameter int NUM_CS        = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    spi_frame_sequencer_if.master bus
);
    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_FETCH,
        ST_WAIT,
        ST_GAP,
        ST_HOLD
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [7:0]               r_delay;
    logic [7:0]               w_delay_nxt;
    logic [7:0]               r_words_left;
    logic [7:0]               w_words_nxt;
    logic [NUM_CS-1:0]        r_cs_n;
    logic [NUM_CS-1:0]        w_cs_n_nxt;
    logic [NUM_CS-1:0]        w_cs_decode;
    logic                     r_core_start;
    logic                     w_core_start_nxt;
    logic [MAX_WORD_SIZE-1:0] r_send;
    logic [MAX_WORD_SIZE-1:0] w_send_nxt;
    logic                     r_discard;
    logic [7:0]               r_gap;
    logic [7:0]               r_hold;
    logic                     r_rx_valid;
    logic [MAX_WORD_SIZE-1:0] r_rx_data;
    logic                     w_cmd_ready;
    logic                     w_tx_ready;
    logic                     w_latch_cmd;
    logic                     w_rx_load;
    logic                     w_rx_take;

    // An out-of-range index matches no select line, so the burst runs with all CS_N high.
    always_comb begin
        w_cs_decode = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (bus.cmdCs == CSW'(i)) begin
                w_cs_decode[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_delay_nxt      = r_delay;
        w_words_nxt      = r_words_left;
        w_cs_n_nxt       = r_cs_n;
        w_core_start_nxt = 1'b0;
        w_send_nxt       = r_send;
        w_cmd_ready      = 1'b0;
        w_tx_ready       = 1'b0;
        w_latch_cmd      = 1'b0;
        w_rx_load        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmdValid) begin
                    w_latch_cmd = 1'b1;
                    w_cs_n_nxt  = w_cs_decode;
                    w_delay_nxt = bus.setupCycles;
                    w_words_nxt = bus.cmdWords;
                    w_state_nxt = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (r_delay == 8'd0) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_delay_nxt = r_delay - 8'd1;
                end
            end

            ST_FETCH: begin
                w_tx_ready = (!r_rx_valid || bus.rxReady || r_discard) && !bus.coreBusy;
                if (w_tx_ready && bus.txValid) begin
                    w_core_start_nxt = 1'b1;
                    w_send_nxt       = bus.txData;
                    w_state_nxt      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.coreReady) begin
                    w_rx_load   = !r_discard;
                    w_words_nxt = r_words_left - 8'd1;
                    // A count of 0 means 256, so only a remaining count of 1 ends the burst.
                    if (r_words_left != 8'd1) begin
                        if (r_gap == 8'd0) begin
                            w_state_nxt = ST_FETCH;
                        end else begin
                            w_delay_nxt = r_gap;
                            w_state_nxt = ST_GAP;
                        end
                    end else begin
                        w_delay_nxt = r_hold;
                        w_state_nxt = ST_HOLD;
                        if (r_hold == 8'd0) begin
                            w_cs_n_nxt = '1;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (r_delay <= 8'd1) begin
                    w_delay_nxt = 8'd0;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_delay_nxt = r_delay - 8'd1;
                end
            end

            ST_HOLD: begin
                // CS_N rises holdCycles+1 cycles after coreReady; IDLE follows one cycle later.
                if (r_delay == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_delay_nxt = r_delay - 8'd1;
                    if (r_delay == 8'd1) begin
                        w_cs_n_nxt = '1;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cs_n_nxt  = '1;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_delay      <= 8'd0;
            r_words_left <= 8'd0;
            r_cs_n       <= '1;
            r_core_start <= 1'b0;
            r_send       <= '0;
            r_discard    <= 1'b0;
            r_gap        <= 8'd0;
            r_hold       <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_delay      <= w_delay_nxt;
            r_words_left <= w_words_nxt;
            r_cs_n       <= w_cs_n_nxt;
            r_core_start <= w_core_start_nxt;
            r_send       <= w_send_nxt;
            if (w_latch_cmd) begin
                r_discard <= bus.cmdRxDiscard;
                r_gap     <= bus.gapCycles;
                r_hold    <= bus.holdCycles;
            end
        end
    end

    assign w_rx_take = r_rx_valid && bus.rxReady;

    // The RX slot lives independently of the FSM so the last word can drain after IDLE.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
        end else if (w_rx_load) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= bus.coreRecvData;
        end else if (w_rx_take) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign bus.cmdReady     = w_cmd_ready;
    assign bus.txReady      = w_tx_ready;
    assign bus.rxValid      = r_rx_valid;
    assign bus.rxData       = r_rx_data;
    assign bus.coreStart    = r_core_start;
    assign bus.coreSendData = r_send;
    assign bus.CS_N         = r_cs_n;
    assign bus.active       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// Scoreboard bench for spi_frame_sequencer: a loopback SpiBase model, randomized bursts,
// and directed timing/reset/out-of-range chip-select scenarios.
module tb_spi_frame_sequencer;
    localparam int W   = 32;
    localparam int NCS = 4;

    typedef struct {
        logic [W-1:0]   data;
        logic [NCS-1:0] mask;
    } start_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_frame_sequencer_if #(.MAX_WORD_SIZE(W), .NUM_CS(NCS)) bus ();
    spi_frame_sequencer_if #(.MAX_WORD_SIZE(W), .NUM_CS(3))   bus2 ();

    spi_frame_sequencer #(.MAX_WORD_SIZE(W), .NUM_CS(NCS)) dut (
        .i_clock(clk), .i_reset(rst), .bus(bus)
    );
    spi_frame_sequencer #(.MAX_WORD_SIZE(W), .NUM_CS(3)) dut2 (
        .i_clock(clk), .i_reset(rst), .bus(bus2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] tx_q[$];
    start_t       exp_start_q[$];
    logic [W-1:0] exp_rx_q[$];
    int           t_start_q[$];
    int           t_ready_q[$];
    int           t_txr_q[$];
    int           t_cs_fall = 0, t_cs_rise = 0, t_cmdr_rise = 0;
    int           n_starts = 0, n_rx = 0, n_rxv_cycles = 0;

    int rx_mode   = 1;
    int core_lat  = 1;
    bit tx_always = 1'b1;

    bit             m_tx_hs, m_start, m2_tx_hs, m2_start;
    logic [W-1:0]   m_send, m2_send;
    bit             m_txr_prev, m_cmdr_prev;
    logic [NCS-1:0] m_cs_prev;
    int             b2_rx = 0, b2_cs_low = 0, b2_txn = 0;

    bit           core_busy;
    int           core_cnt;
    logic [W-1:0] core_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a start or an RX word.
    always @(negedge clk) begin
        if (rst) begin
            m_tx_hs     = 1'b0;
            m_start     = 1'b0;
            m2_tx_hs    = 1'b0;
            m2_start    = 1'b0;
            m_cs_prev   = '1;
            m_txr_prev  = 1'b0;
            m_cmdr_prev = 1'b1;
        end else begin
            if (bus.coreStart) begin
                n_starts++;
                t_start_q.push_back(cyc);
                if (exp_start_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_start: got data %0h, none expected", bus.coreSendData);
                end else begin
                    start_t e;
                    e = exp_start_q.pop_front();
                    chk("send_data", bus.coreSendData, e.data);
                    chk("cs_n_at_start", bus.CS_N, e.mask);
                end
            end
            if (bus.rxValid) n_rxv_cycles++;
            if (bus.rxValid && bus.rxReady) begin
                n_rx++;
                if (exp_rx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rx: got %0h, none expected", bus.rxData);
                end else begin
                    chk("rx_data", bus.rxData, exp_rx_q.pop_front());
                end
            end
            if (bus.coreReady) t_ready_q.push_back(cyc);
            if (bus.txReady && !m_txr_prev) t_txr_q.push_back(cyc);
            if (bus.CS_N != '1 && m_cs_prev == '1) t_cs_fall = cyc;
            if (bus.CS_N == '1 && m_cs_prev != '1) t_cs_rise = cyc;
            if (bus.cmdReady && !m_cmdr_prev) t_cmdr_rise = cyc;
            m_tx_hs     = bus.txValid && bus.txReady;
            m_start     = bus.coreStart;
            m_send      = bus.coreSendData;
            m_txr_prev  = bus.txReady;
            m_cmdr_prev = bus.cmdReady;
            m_cs_prev   = bus.CS_N;

            if (bus2.CS_N != 3'b111) b2_cs_low++;
            if (bus2.rxValid && bus2.rxReady) begin
                chk("t6_rx_data", bus2.rxData, 32'hC0DE0000 + b2_rx);
                b2_rx++;
            end
            m2_tx_hs = bus2.txValid && bus2.txReady;
            m2_start = bus2.coreStart;
            m2_send  = bus2.coreSendData;
        end
    end

    // Drivers: TX feeder, RX consumer and loopback SpiBase models, updated just after each edge.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.txValid       = 1'b0;
            bus.txData        = '0;
            bus.rxReady       = 1'b0;
            bus.coreReady     = 1'b0;
            bus.coreBusy      = 1'b0;
            bus.coreRecvData  = '0;
            bus2.txValid      = 1'b0;
            bus2.txData       = '0;
            bus2.rxReady      = 1'b0;
            bus2.coreReady    = 1'b0;
            bus2.coreBusy     = 1'b0;
            bus2.coreRecvData = '0;
            core_busy         = 1'b0;
            core_cnt          = 0;
        end else begin
            if (m_tx_hs && tx_q.size() > 0) void'(tx_q.pop_front());
            bus.txValid = (tx_q.size() > 0) && (tx_always || $urandom_range(0, 3) != 0);
            bus.txData  = (tx_q.size() > 0) ? tx_q[0] : '0;
            case (rx_mode)
                0:       bus.rxReady = ($urandom_range(0, 1) == 1);
                1:       bus.rxReady = 1'b1;
                default: bus.rxReady = 1'b0;
            endcase
            bus.coreReady = 1'b0;
            if (m_start) begin
                core_busy = 1'b1;
                core_cnt  = (core_lat > 0) ? core_lat : int'($urandom_range(1, 3));
                core_data = m_send;
            end else if (core_busy) begin
                if (core_cnt > 1) begin
                    core_cnt--;
                end else begin
                    bus.coreReady    = 1'b1;
                    bus.coreRecvData = core_data;
                    core_busy        = 1'b0;
                end
            end
            bus.coreBusy = core_busy;

            if (m2_tx_hs) b2_txn++;
            bus2.txValid      = 1'b1;
            bus2.txData       = 32'hC0DE0000 + b2_txn;
            bus2.rxReady      = 1'b1;
            bus2.coreReady    = m2_start;
            bus2.coreRecvData = m2_send;
            bus2.coreBusy     = 1'b0;
        end
    end

    // Reference model: a burst of n words sends each TX word once, in order, under the
    // selected CS line, and returns the same words (loopback core) unless discarded.
    task automatic issue(input int cs, input int words, input bit disc, input int su,
                         input int gp, input int hd, input logic [W-1:0] base);
        int             n;
        logic [NCS-1:0] mask;
        logic [W-1:0]   d;
        bit             ok;
        start_t         e;
        n    = (words == 0) ? 256 : words;
        mask = '1;
        if (cs < NCS) mask[cs] = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = (base != '0) ? base + W'(i) : W'($urandom);
            tx_q.push_back(d);
            e.data = d;
            e.mask = mask;
            exp_start_q.push_back(e);
            if (!disc) exp_rx_q.push_back(d);
        end
        @(posedge clk);
        #1;
        bus.cmdCs        = 2'(cs);
        bus.cmdWords     = 8'(words);
        bus.cmdRxDiscard = disc;
        bus.setupCycles  = 8'(su);
        bus.gapCycles    = 8'(gp);
        bus.holdCycles   = 8'(hd);
        bus.cmdValid     = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.cmdReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL cmd_accept_timeout: cmdReady stayed 0, required 1");
        end
        @(posedge clk);
        #1;
        bus.cmdValid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int bound);
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            #1;
            if (exp_start_q.size() == 0 && exp_rx_q.size() == 0 && !bus.active) break;
        end
        chk({nm, "_drained"}, 64'(exp_start_q.size() + exp_rx_q.size()), 64'd0);
        chk({nm, "_idle"}, {bus.active, bus.CS_N}, {1'b0, 4'hF});
    endtask

    task automatic clear_times();
        t_start_q.delete();
        t_ready_q.delete();
        t_txr_q.delete();
    endtask

    initial begin
        int  s0, r0, v0;
        bit  ok;
        bus.cmdValid      = 1'b0;
        bus.cmdCs         = '0;
        bus.cmdWords      = '0;
        bus.cmdRxDiscard  = 1'b0;
        bus.setupCycles   = '0;
        bus.gapCycles     = '0;
        bus.holdCycles    = '0;
        bus2.cmdValid     = 1'b0;
        bus2.cmdCs        = '0;
        bus2.cmdWords     = '0;
        bus2.cmdRxDiscard = 1'b0;
        bus2.setupCycles  = '0;
        bus2.gapCycles    = '0;
        bus2.holdCycles   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cs_n", bus.CS_N, 4'hF);
        chk("reset_core_start", bus.coreStart, 1'b0);
        chk("reset_send_data", bus.coreSendData, 32'h0);
        chk("reset_rx", {bus.rxValid, bus.rxData}, 33'h0);
        chk("reset_ready_active", {bus.txReady, bus.cmdReady, bus.active}, 3'b010);
        rst = 1'b0;

        // 1: single word, no delays
        rx_mode = 1; core_lat = 1; tx_always = 1'b1;
        clear_times();
        s0 = n_starts;
        issue(2, 1, 1'b0, 0, 0, 0, 32'hA5A5A5A5);
        wait_done("t1", 200);
        chk("t1_starts", 64'(n_starts - s0), 64'd1);
        chk("t1_ready_seen", 64'(t_ready_q.size()), 64'd1);
        if (t_ready_q.size() > 0) chk("t1_cs_rise_delay", 64'(t_cs_rise - t_ready_q[0]), 64'd1);
        chk("t1_cmdready_after_cs", 64'(t_cmdr_rise - t_cs_rise), 64'd1);

        // 2: setup/gap/hold timing
        core_lat = 2;
        clear_times();
        issue(0, 3, 1'b0, 3, 5, 4, '0);
        wait_done("t2", 400);
        chk("t2_counts", {32'(t_ready_q.size()), 32'(t_txr_q.size())}, {32'd3, 32'd3});
        if (t_start_q.size() > 0) chk("t2_setup", 64'(t_start_q[0] - t_cs_fall), 64'd5);
        if (t_ready_q.size() == 3 && t_txr_q.size() == 3) begin
            chk("t2_gap1", 64'(t_txr_q[1] - t_ready_q[0] - 1), 64'd5);
            chk("t2_gap2", 64'(t_txr_q[2] - t_ready_q[1] - 1), 64'd5);
            chk("t2_hold", 64'(t_cs_rise - t_ready_q[2]), 64'd5);
        end

        // 3: RX backpressure stalls issuing
        rx_mode = 2; core_lat = 1;
        s0 = n_starts;
        issue(1, 4, 1'b0, 0, 0, 0, 32'h1);
        repeat (40) @(negedge clk);
        #1;
        chk("t3_stalled_starts", 64'(n_starts - s0), 64'd1);
        chk("t3_held_word", {bus.rxValid, bus.rxData}, {1'b1, 32'h1});
        rx_mode = 1;
        wait_done("t3", 300);
        chk("t3_starts", 64'(n_starts - s0), 64'd4);

        // 4: 256-word burst with RX discarded
        rx_mode = 0; core_lat = 1;
        s0 = n_starts; r0 = n_rx; v0 = n_rxv_cycles;
        issue(0, 0, 1'b1, 0, 0, 0, '0);
        wait_done("t4", 6000);
        chk("t4_starts", 64'(n_starts - s0), 64'd256);
        chk("t4_rx_valid_cycles", 64'(n_rxv_cycles - v0), 64'd0);
        chk("t4_rx_words", 64'(n_rx - r0), 64'd0);

        // 5: asynchronous reset during word 2 of 3
        rx_mode = 1; core_lat = 4;
        s0 = n_starts;
        issue(3, 3, 1'b0, 0, 0, 0, '0);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (n_starts - s0 >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t5_reached_word2", ok, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_cs_n_on_reset", bus.CS_N, 4'hF);
        chk("t5_active_on_reset", {bus.active, bus.coreStart}, 2'b00);
        tx_q.delete();
        exp_start_q.delete();
        exp_rx_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        s0 = n_starts;
        repeat (15) @(negedge clk);
        #1;
        chk("t5_no_start_after_reset", 64'(n_starts - s0), 64'd0);
        core_lat = 0;
        issue(1, 3, 1'b0, 1, 1, 1, '0);
        wait_done("t5_after", 500);
        chk("t5_after_starts", 64'(n_starts - s0), 64'd3);

        // Randomized back-to-back bursts
        rx_mode = 0; core_lat = 0; tx_always = 1'b0;
        for (int b = 0; b < 20; b++) begin
            issue(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), '0);
        end
        wait_done("rand", 4000);

        // 6: out-of-range chip select on the 3-CS instance
        @(posedge clk);
        #1;
        bus2.cmdCs    = 2'd3;
        bus2.cmdWords = 8'd2;
        bus2.cmdValid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus2.cmdReady) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_cmd_accept", ok, 1'b1);
        @(posedge clk);
        #1;
        bus2.cmdValid = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (b2_rx == 2 && !bus2.active) break;
        end
        chk("t6_rx_count", 64'(b2_rx), 64'd2);
        chk("t6_cs_low_cycles", 64'(b2_cs_low), 64'd0);
        chk("t6_idle", {bus2.active, bus2.CS_N}, {1'b0, 3'b111});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, run did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end
endmodule
